instruction_fetch_unit: RTL

- Initiator side of the instruction memory read interface.
- Owns the program counter and drives a word address to the combinational instruction memory, which returns data in the same cycle.
- Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports enable/stall, back-pressure, branch redirect with flush, and PC wrap-around.

---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Initiator side of the instruction-memory read interface. Owns the program
// counter, presents it as a word address to a combinational instruction
// memory, and buffers each fetched word together with its address in a small
// prefetch FIFO. Decode consumes the FIFO head over a valid/ready handshake.
// A branch redirect flushes the FIFO and reloads the PC.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       fetch permitted this cycle (0 stalls the PC, pops continue)
//   imem_addr    word address to instruction memory (the PC register)
//   imem_data    instruction word returned combinationally for imem_addr
//   redirect     one-cycle branch/jump request; wins over push and pop
//   redirect_pc  target word address, valid when redirect=1
//   inst_valid   FIFO head holds an instruction
//   inst_ready   decode accepts the head this cycle
//   inst_data    head instruction word
//   inst_pc      word address of the head instruction
//   fifo_count   FIFO occupancy (debug/perf)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DATA_W-1:0]          inst_data,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic push;
  logic pop;

  // A full FIFO may still accept a word when the head leaves in the same
  // cycle; this is what sustains one instruction per cycle at DEPTH entries.
  assign pop  = inst_valid & inst_ready;
  assign push = enable & ~redirect & ((count < FULL_CNT) | pop);

  // imem_addr comes straight from the PC flop, so neither inst_ready nor
  // redirect can reach the memory address combinationally.
  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_data  = data_q[rd_ptr];
  assign inst_pc    = pc_q[rd_ptr];
  assign fifo_count = count;

  // Program counter: redirect loads the target, a push advances by one and
  // wraps silently at 2^ADDR_W.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  // Pointers and occupancy. Redirect flushes everything, including a pop that
  // happens in the same cycle; decode discards on redirect as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. The head is read combinationally, so a word written at an
  // edge is visible at the head right after that edge.
  // NOTE: the storage is reset because inst_data/inst_pc must read zero out of
  // reset; at DEPTH flops per field the reset costs nothing worth avoiding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr] <= imem_data;
      pc_q[wr_ptr]   <= pc;
    end
  end

endmodule
